// File: rtl/set_scan_ctrl.sv
// Scan sequencer for the SET grid datapath: four two-row passes over the 8x8 grid,
// counting membership hits returned HIT_LAT cycles after each valid point.
module set_scan_ctrl #(
    parameter int unsigned HIT_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       hit_i,
    output logic       busy_o,
    output logic       coord_en_o,
    output logic [3:0] start_row_o,
    output logic       pt_valid_o,
    output logic [6:0] count_o,
    output logic       done_o
);

    localparam int unsigned PASS_W  = 2;
    localparam int unsigned PT_W    = 4;
    localparam int unsigned DRAIN_W = 3;
    localparam int unsigned ACC_W   = 7;
    localparam int unsigned ROW_W   = 4;

    localparam logic [PASS_W-1:0]  PASS_LAST  = PASS_W'(3);
    localparam logic [PT_W-1:0]    PT_LAST    = PT_W'(15);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((HIT_LAT == 0) ? 0 : HIT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PASS_W-1:0]   pass;
    logic [PASS_W-1:0]   pass_next;
    logic [PT_W-1:0]     pt_cnt;
    logic [PT_W-1:0]     pt_cnt_next;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [DRAIN_W-1:0]  drain_next;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    count_next;
    logic [ROW_W-1:0]    row_next;
    logic                dv_c;
    logic                hit_c;
    logic                abort_c;

    // Abort only acts on an active scan; IDLE and the DONE cycle ignore it.
    assign abort_c = abort_i && (state == S_LOAD || state == S_SCAN || state == S_DRAIN);
    assign hit_c   = dv_c && hit_i;

    // Valid delay line aligning each point with its hit_i result.
    generate
        if (HIT_LAT == 0) begin : g_no_lat
            assign dv_c = pt_valid_o;
        end else begin : g_lat
            logic [HIT_LAT-1:0] dly;
            always_ff @(posedge clk_i) begin
                if (rst_i || abort_c) begin
                    dly <= '0;
                end else begin
                    dly <= HIT_LAT'({dly, pt_valid_o});
                end
            end
            assign dv_c = dly[HIT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pass_next   = pass;
        pt_cnt_next = pt_cnt;
        drain_next  = drain_cnt;
        acc_next    = acc + ACC_W'(hit_c);
        count_next  = count_o;
        row_next    = start_row_o;

        case (state)
            S_IDLE: begin
                acc_next = acc;
                if (start_i) begin
                    state_next = S_LOAD;
                    pass_next  = '0;
                    acc_next   = '0;
                end
            end
            S_LOAD: begin
                pt_cnt_next = '0;
                state_next  = S_SCAN;
            end
            S_SCAN: begin
                pt_cnt_next = pt_cnt + PT_W'(1);
                if (pt_cnt == PT_LAST) begin
                    if (pass != PASS_LAST) begin
                        pass_next  = pass + PASS_W'(1);
                        state_next = S_LOAD;
                    end else if (HIT_LAT == 0) begin
                        state_next = S_DONE;
                    end else begin
                        drain_next = '0;
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_cnt + DRAIN_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort_c) begin
            state_next = S_IDLE;
        end

        // Row for the coming LOAD is 2*pass+1; the final hit lands in count on entry to DONE.
        if (state_next == S_LOAD) begin
            row_next = ROW_W'({pass_next, 1'b1});
        end
        if (state_next == S_DONE) begin
            count_next = acc_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass        <= '0;
            pt_cnt      <= '0;
            drain_cnt   <= '0;
            acc         <= '0;
            count_o     <= '0;
            start_row_o <= ROW_W'(1);
            busy_o      <= 1'b0;
            coord_en_o  <= 1'b0;
            pt_valid_o  <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            pass        <= pass_next;
            pt_cnt      <= pt_cnt_next;
            drain_cnt   <= drain_next;
            acc         <= acc_next;
            count_o     <= count_next;
            start_row_o <= row_next;
            busy_o      <= (state_next != S_IDLE);
            coord_en_o  <= (state_next == S_LOAD);
            pt_valid_o  <= (state_next == S_SCAN);
            done_o      <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_set_scan_ctrl.sv
// Randomized self-checking bench for set_scan_ctrl; three builds (HIT_LAT 0, 1, 4)
// are checked cycle by cycle against a grid-level model of the scan timeline.
module tb_set_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start    [3];
    logic       abort    [3];
    logic       hit      [3];
    logic       busy     [3];
    logic       coord_en [3];
    logic       pt_valid [3];
    logic       done     [3];
    logic [3:0] row      [3];
    logic [6:0] count    [3];

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] cnt_model [3];
    logic [3:0] row_model [3];
    bit         pat [64];
    int         obs_done_cyc;
    int         obs_en_pulses;
    int         obs_valid_cyc;
    logic [6:0] obs_count;
    logic [6:0] last_exp;

    set_scan_ctrl #(.HIT_LAT(0)) u_lat0 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort[0]), .hit_i(hit[0]),
        .busy_o(busy[0]), .coord_en_o(coord_en[0]), .start_row_o(row[0]),
        .pt_valid_o(pt_valid[0]), .count_o(count[0]), .done_o(done[0]));

    set_scan_ctrl #(.HIT_LAT(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort[1]), .hit_i(hit[1]),
        .busy_o(busy[1]), .coord_en_o(coord_en[1]), .start_row_o(row[1]),
        .pt_valid_o(pt_valid[1]), .count_o(count[1]), .done_o(done[1]));

    set_scan_ctrl #(.HIT_LAT(4)) u_lat4 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .abort_i(abort[2]), .hit_i(hit[2]),
        .busy_o(busy[2]), .coord_en_o(coord_en[2]), .start_row_o(row[2]),
        .pt_valid_o(pt_valid[2]), .count_o(count[2]), .done_o(done[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 4);
    endfunction

    // Grid point index (16*pass + offset) shown in cycle c, or -1 for a non-point cycle.
    function automatic int point_at(input int c);
        for (int k = 0; k < 4; k++) begin
            if (c - 2 - 17 * k >= 0 && c - 2 - 17 * k < 16) return 16 * k + (c - 2 - 17 * k);
        end
        return -1;
    endfunction

    function automatic int load_at(input int c);
        for (int k = 0; k < 4; k++) begin
            if (c == 1 + 17 * k) return k;
        end
        return -1;
    endfunction

    // Drives one scan (start in cycle 0) and checks every output each cycle.
    // mode: 0 all hits, 1 alternate hits + gap hits, 2 last point only, 3 random.
    task automatic run_scan(input int d, input int mode, input int abort_cyc, input int rst_cyc,
                            input bit extra, input bit abort_done);
        int         lat;
        int         done_c;
        int         last;
        int         ecount;
        int         idx;
        int         k;
        logic       e_busy, e_en, e_valid, e_done;
        logic [3:0] e_row;
        logic [6:0] e_cnt;
        lat    = lat_of(d);
        done_c = 69 + lat;
        ecount = 0;
        for (int p = 0; p < 64; p++) begin
            case (mode)
                0:       pat[p] = 1'b1;
                1:       pat[p] = (p % 2 == 0);
                2:       pat[p] = (p == 63);
                default: pat[p] = 1'($urandom_range(0, 1));
            endcase
            ecount += int'(pat[p]);
        end
        last_exp = 7'(ecount);
        last = (abort_cyc >= 0) ? abort_cyc + 1 : ((rst_cyc >= 0) ? rst_cyc + 1 : done_c + 1);
        obs_done_cyc  = -1;
        obs_en_pulses = 0;
        obs_valid_cyc = 0;
        start[d] = 1'b1;
        abort[d] = 1'b0;
        hit[d]   = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            start[d] = extra && ((c < done_c && $urandom_range(0, 2) == 0) || c == done_c);
            abort[d] = (c == abort_cyc) || (abort_done && c == done_c);
            rst      = (rst_cyc >= 0 && c == rst_cyc);
            idx      = point_at(c - lat);
            hit[d]   = (idx >= 0) ? pat[idx] : ((mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (rst_cyc >= 0 && c > rst_cyc) begin
                {e_busy, e_en, e_valid, e_done} = 4'b0000;
                e_row = 4'd1;
                e_cnt = 7'd0;
            end else if (abort_cyc >= 0 && c > abort_cyc) begin
                {e_busy, e_en, e_valid, e_done} = 4'b0000;
                e_row = row_model[d];
                e_cnt = cnt_model[d];
            end else begin
                k = load_at(c);
                if (k >= 0) row_model[d] = 4'(2 * k + 1);
                e_en    = (k >= 0);
                e_valid = (point_at(c) >= 0);
                e_busy  = (c <= done_c);
                e_done  = (c == done_c);
                e_row   = row_model[d];
                e_cnt   = (c >= done_c) ? 7'(ecount) : cnt_model[d];
            end
            n_cmp += 6;
            if (busy[d] !== e_busy) begin
                n_err++;
                $display("FAIL busy lat%0d cyc%0d: got %b want %b", lat, c, busy[d], e_busy);
            end
            if (coord_en[d] !== e_en) begin
                n_err++;
                $display("FAIL coord_en lat%0d cyc%0d: got %b want %b", lat, c, coord_en[d], e_en);
            end
            if (row[d] !== e_row) begin
                n_err++;
                $display("FAIL start_row lat%0d cyc%0d: got %0d want %0d", lat, c, row[d], e_row);
            end
            if (pt_valid[d] !== e_valid) begin
                n_err++;
                $display("FAIL pt_valid lat%0d cyc%0d: got %b want %b", lat, c, pt_valid[d], e_valid);
            end
            if (done[d] !== e_done) begin
                n_err++;
                $display("FAIL done lat%0d cyc%0d: got %b want %b", lat, c, done[d], e_done);
            end
            if (count[d] !== e_cnt) begin
                n_err++;
                $display("FAIL count lat%0d cyc%0d: got %0d want %0d", lat, c, count[d], e_cnt);
            end
            if (done[d] === 1'b1 && obs_done_cyc < 0) obs_done_cyc = c;
            if (coord_en[d] === 1'b1) obs_en_pulses++;
            if (pt_valid[d] === 1'b1) obs_valid_cyc++;
            obs_count = count[d];
        end
        start[d] = 1'b0;
        abort[d] = 1'b0;
        hit[d]   = 1'b0;
        rst      = 1'b0;
        if (rst_cyc >= 0) begin
            for (int i = 0; i < 3; i++) begin
                cnt_model[i] = 7'd0;
                row_model[i] = 4'd1;
            end
        end else if (abort_cyc < 0) begin
            cnt_model[d] = 7'(ecount);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_cmp += 6;
            if ({busy[d], coord_en[d], pt_valid[d], done[d]} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_strobes d%0d: got %b want 0000", d,
                         {busy[d], coord_en[d], pt_valid[d], done[d]});
                n_err += 3;
            end
            if (row[d] !== 4'd1) begin
                n_err++;
                $display("FAIL reset_row d%0d: got %0d want 1", d, row[d]);
            end
            if (count[d] !== 7'd0) begin
                n_err++;
                $display("FAIL reset_count d%0d: got %0d want 0", d, count[d]);
            end
            cnt_model[d] = 7'd0;
            row_model[d] = 4'd1;
        end
        rst = 1'b0;
    endtask

    task automatic test_full_hits();
        run_scan(1, 0, -1, -1, 1'b0, 1'b0);
        n_cmp += 4;
        if (obs_done_cyc !== 70) begin
            n_err++; $display("FAIL full_done_cycle: got %0d want 70", obs_done_cyc);
        end
        if (obs_count !== 7'd64) begin
            n_err++; $display("FAIL full_count: got %0d want 64", obs_count);
        end
        if (obs_en_pulses !== 4) begin
            n_err++; $display("FAIL full_load_pulses: got %0d want 4", obs_en_pulses);
        end
        if (obs_valid_cyc !== 64) begin
            n_err++; $display("FAIL full_valid_cycles: got %0d want 64", obs_valid_cyc);
        end
        idle(3);
    endtask

    task automatic test_alternate();
        run_scan(1, 1, -1, -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_count !== 7'd32) begin
            n_err++; $display("FAIL alternate_count: got %0d want 32", obs_count);
        end
        idle(2);
    endtask

    task automatic test_latency();
        run_scan(0, 2, -1, -1, 1'b0, 1'b0);
        n_cmp += 2;
        if (obs_done_cyc !== 69) begin
            n_err++; $display("FAIL lat0_done_cycle: got %0d want 69", obs_done_cyc);
        end
        if (obs_count !== 7'd1) begin
            n_err++; $display("FAIL lat0_count: got %0d want 1", obs_count);
        end
        idle(2);
        run_scan(2, 2, -1, -1, 1'b0, 1'b0);
        n_cmp += 2;
        if (obs_done_cyc !== 73) begin
            n_err++; $display("FAIL lat4_done_cycle: got %0d want 73", obs_done_cyc);
        end
        if (obs_count !== 7'd1) begin
            n_err++; $display("FAIL lat4_count: got %0d want 1", obs_count);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++) begin
                run_scan(d, 3, -1, -1, 1'b0, 1'b0);
                n_cmp++;
                if (obs_count !== last_exp) begin
                    n_err++; $display("FAIL random_count d%0d: got %0d want %0d", d, obs_count, last_exp);
                end
                idle(int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_abort();
        run_scan(1, 0, -1, -1, 1'b0, 1'b0);
        idle(2);
        run_scan(1, 3, 30, -1, 1'b0, 1'b0);
        n_cmp += 2;
        if (obs_count !== 7'd64) begin
            n_err++; $display("FAIL abort_count_held: got %0d want 64", obs_count);
        end
        if (obs_done_cyc !== -1) begin
            n_err++; $display("FAIL abort_no_done: got done at %0d want none", obs_done_cyc);
        end
        idle(2);
        // Abort deep in a pass with hits in flight, then restart at once: stale valids must not count.
        run_scan(2, 0, 40, -1, 1'b0, 1'b0);
        run_scan(2, 1, -1, -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_count !== 7'd32) begin
            n_err++; $display("FAIL abort_restart_count: got %0d want 32", obs_count);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        run_scan(1, 3, -1, -1, 1'b1, 1'b1);
        n_cmp += 2;
        if (obs_done_cyc !== 70) begin
            n_err++; $display("FAIL b2b_done_cycle: got %0d want 70", obs_done_cyc);
        end
        if (obs_count !== last_exp) begin
            n_err++; $display("FAIL b2b_count: got %0d want %0d", obs_count, last_exp);
        end
        run_scan(1, 0, -1, -1, 1'b0, 1'b0);
        n_cmp++;
        if (obs_done_cyc !== 70) begin
            n_err++; $display("FAIL b2b_second_done: got %0d want 70", obs_done_cyc);
        end
        idle(2);
    endtask

    task automatic test_reset_mid();
        run_scan(1, 3, -1, 40, 1'b0, 1'b0);
        n_cmp++;
        if (obs_count !== 7'd0) begin
            n_err++; $display("FAIL midreset_count: got %0d want 0", obs_count);
        end
        idle(1);
        run_scan(1, 2, -1, -1, 1'b0, 1'b0);
        n_cmp += 2;
        if (obs_count !== 7'd1) begin
            n_err++; $display("FAIL midreset_rescan_count: got %0d want 1", obs_count);
        end
        if (obs_en_pulses !== 4) begin
            n_err++; $display("FAIL midreset_rescan_loads: got %0d want 4", obs_en_pulses);
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
            hit[d]   = 1'b0;
        end
        test_reset();
        test_full_hits();
        test_alternate();
        test_latency();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
